data_ram_resp: RTL and testbench
================================

DATA_RAM_RESP -- requirements
Module: data_ram_resp

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024: RAM size in 32-bit words, power of 2.
REQ-002 Parameter WB_DEPTH, default 4: posted-write buffer entries, power of 2, >= 2.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 memWriteM  input  1  CPU M-stage store request.
REQ-006 memReadM  input  1  CPU M-stage load request.
REQ-007 data_ram_waddr  input  32  CPU byte address, used for both loads and stores.
REQ-008 data_ram_wdataM  input  32  store data.
REQ-009 data_ram_rdata  output  32  load data, combinational.
REQ-010 mem_stall  output  1  CPU shall hold the M-stage request while high.
REQ-011 wb_empty  output  1  high when the write buffer holds no entries.

Function
REQ-012 Word index SHALL be data_ram_waddr[log2(DEPTH_WORDS)+1:2]; bits [1:0] and higher bits are ignored, so addresses wrap modulo DEPTH_WORDS.
REQ-013 A store SHALL be accepted when memWriteM=1 and mem_stall=0; {index, data} is enqueued at the tail on that edge.
REQ-014 mem_stall SHALL be 1 when memWriteM=1 and count==WB_DEPTH, regardless of any same-cycle drain.
REQ-015 Drain: when count>0 and (memReadM=0 or the load is hazard-stalled per REQ-025), the head entry SHALL be written to RAM and popped on that edge.
REQ-016 Enqueue and drain in the same cycle SHALL leave count unchanged; head/tail pointers wrap modulo WB_DEPTH.
REQ-017 Buffer state: EMPTY (count=0), PARTIAL (0<count<WB_DEPTH), FULL (count=WB_DEPTH); transitions follow count only.
REQ-018 Drain order SHALL be strict FIFO; two stores to one index both occupy entries and both reach RAM in order.
REQ-019 With memReadM=1 and no stall, data_ram_rdata SHALL be the youngest valid buffer entry matching the index, otherwise RAM[index].
REQ-020 With memReadM=0, data_ram_rdata SHALL be 32'h0.
REQ-021 A load SHALL observe buffer/RAM state before the current edge; a same-cycle store is not visible to it.
REQ-022 memReadM and memWriteM both high SHALL be serviced: load per REQ-019, store per REQ-013.

Reset
REQ-023 On rst high: count=0, pointers=0, all entry valid bits cleared, wb_empty=1, mem_stall=0; pending buffered stores are discarded, including mid-drain.
REQ-024 RAM contents SHALL NOT be reset.

Configuration
REQ-025 Macro DRAM_WB_FWD_EN defined: REQ-019 forwarding is active and a load never stalls. Undefined: a load whose index matches any valid entry SHALL assert mem_stall and drain continues each cycle until no match; data_ram_rdata then comes from RAM.

Structure
REQ-026 Package dram_pkg SHALL hold the write-buffer entry typedef {valid, index, data}, the buffer-state enum, and the default parameter constants.
REQ-027 Sub-module wb_fifo SHALL implement the buffer with pointers, count, and the youngest-match address compare; data_ram_resp holds the RAM array and muxing.

Verification
REQ-028 Store 0x10<-0xDEADBEEF, then load 0x10 next cycle -> rdata=0xDEADBEEF (fwd build: no stall; non-fwd: stall until drained, then 0xDEADBEEF).
REQ-029 Five back-to-back stores with memReadM=1 held (no drain) -> stall on 5th, wb_empty=0; drop memReadM -> 5th accepted after one drain.
REQ-030 Stores 0x20<-1, 0x20<-2, load 0x20 -> rdata=2 (fwd); after full drain RAM[8]=2.
REQ-031 Address 0x1000 with DEPTH_WORDS=1024 and 0x0002 -> both alias index 0 and index 0 respectively; store 0x1000<-7, load 0x0 -> 7.
REQ-032 Assert rst with 3 pending entries -> wb_empty=1 immediately; load of those addresses returns prior RAM values.
REQ-033 Simultaneous load 0x30 and store 0x30<-9 with RAM[12]=5 -> rdata=5 that cycle, 9 on the next load.

Source files
------------

// File: rtl/dram_pkg.sv
// Shared types and default sizes for the data RAM with posted-write buffer.
package dram_pkg;

  localparam int DEPTH_WORDS_DEF = 1024;
  localparam int WB_DEPTH_DEF    = 4;
  localparam int IDX_MAX_W       = 30;

  typedef struct packed {
    logic                 valid;
    logic [IDX_MAX_W-1:0] index;
    logic [31:0]          data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    WB_EMPTY,
    WB_PARTIAL,
    WB_FULL
  } wb_state_e;

endpackage

// File: rtl/wb_fifo.sv
// Posted-write FIFO: circular entries with head/tail/count and a youngest-match
// lookup used for load forwarding or hazard detection.
module wb_fifo
  import dram_pkg::*;
#(
  parameter int WB_DEPTH = WB_DEPTH_DEF,
  parameter int IDX_W    = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [IDX_W-1:0] push_index,
  input  logic [31:0]      push_data,
  input  logic             pop,
  input  logic [IDX_W-1:0] lookup_index,
  output wb_entry_t        head_ent,
  output wb_state_e        state,
  output logic             hit,
  output logic [31:0]      hit_data
);

  localparam int PW = $clog2(WB_DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t       ent [WB_DEPTH];
  logic [PW-1:0]   head, tail;
  logic [CW-1:0]   count, count_d;
  wb_state_e       state_d;

  always_comb begin
    count_d = count;
    case ({push, pop})
      2'b10:   count_d = count + CW'(1);
      2'b01:   count_d = count - CW'(1);
      default: count_d = count;
    endcase
  end

  // State is a pure function of the post-edge count.
  always_comb begin
    state_d = WB_PARTIAL;
    if (count_d == '0)
      state_d = WB_EMPTY;
    else if (count_d == CW'(WB_DEPTH))
      state_d = WB_FULL;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= WB_EMPTY;
      count <= '0;
      head  <= '0;
      tail  <= '0;
      for (int i = 0; i < WB_DEPTH; i++) ent[i] <= '0;
    end else begin
      state <= state_d;
      count <= count_d;
      if (push) begin
        ent[tail] <= '{valid: 1'b1, index: IDX_MAX_W'(push_index), data: push_data};
        tail      <= tail + PW'(1);
      end
      if (pop) begin
        ent[head].valid <= 1'b0;
        head            <= head + PW'(1);
      end
    end
  end

  assign head_ent = ent[head];

  // Scan oldest to youngest so the last match wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      if (ent[head + PW'(i)].valid &&
          ent[head + PW'(i)].index == IDX_MAX_W'(lookup_index)) begin
        hit      = 1'b1;
        hit_data = ent[head + PW'(i)].data;
      end
    end
  end

endmodule

// File: rtl/data_ram_resp.sv
// Data RAM behind a posted-write buffer. DRAM_WB_FWD_EN enables store-to-load
// forwarding; without it a load that hits a buffered store stalls until drained.
module data_ram_resp
  import dram_pkg::*;
#(
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
  parameter int WB_DEPTH    = WB_DEPTH_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memWriteM,
  input  logic        memReadM,
  input  logic [31:0] data_ram_waddr,
  input  logic [31:0] data_ram_wdataM,
  output logic [31:0] data_ram_rdata,
  output logic        mem_stall,
  output logic        wb_empty
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0]   ram [DEPTH_WORDS];
  logic [AW-1:0] idx;
  logic          push, pop, full, hit, load_hazard;
  logic [31:0]   hit_data;
  wb_entry_t     head_ent;
  wb_state_e     state;

  assign idx = data_ram_waddr[AW+1:2];

  wb_fifo #(.WB_DEPTH(WB_DEPTH), .IDX_W(AW)) u_wb (
    .clk          (clk),
    .rst          (rst),
    .push         (push),
    .push_index   (idx),
    .push_data    (data_ram_wdataM),
    .pop          (pop),
    .lookup_index (idx),
    .head_ent     (head_ent),
    .state        (state),
    .hit          (hit),
    .hit_data     (hit_data)
  );

  assign wb_empty = (state == WB_EMPTY);
  assign full     = (state == WB_FULL);

`ifdef DRAM_WB_FWD_EN
  assign load_hazard = 1'b0;
`else
  assign load_hazard = memReadM & hit;
`endif

  // Full stalls a store even if a drain frees a slot on this edge.
  assign mem_stall = (memWriteM & full) | load_hazard;
  assign push      = memWriteM & ~mem_stall;
  assign pop       = ~wb_empty & (~memReadM | load_hazard);

  always_ff @(posedge clk) begin
    if (pop) ram[head_ent.index[AW-1:0]] <= head_ent.data;
  end

`ifdef DRAM_WB_FWD_EN
  assign data_ram_rdata = !memReadM ? 32'h0 : (hit ? hit_data : ram[idx]);
`else
  assign data_ram_rdata = !memReadM ? 32'h0 : ram[idx];
  logic unused_fwd;
  assign unused_fwd = ^hit_data;
`endif

  logic unused_bits;
  assign unused_bits = ^{data_ram_waddr[31:AW+2], data_ram_waddr[1:0],
                         head_ent.valid, head_ent.index[IDX_MAX_W-1:AW]};

endmodule

// File: tb/tb_data_ram_resp.sv
// Directed bench for data_ram_resp; expectations follow DRAM_WB_FWD_EN.
module tb_data_ram_resp;

  localparam int WB = 4;

  logic        clk = 1'b0;
  logic        rst, memWriteM, memReadM;
  logic [31:0] waddr, wdata, rdata;
  logic        mem_stall, wb_empty;
  int          vectors = 0;
  int          miscompares = 0;

  data_ram_resp #(.DEPTH_WORDS(1024), .WB_DEPTH(WB)) dut (
    .clk             (clk),
    .rst             (rst),
    .memWriteM       (memWriteM),
    .memReadM        (memReadM),
    .data_ram_waddr  (waddr),
    .data_ram_wdataM (wdata),
    .data_ram_rdata  (rdata),
    .mem_stall       (mem_stall),
    .wb_empty        (wb_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
    memWriteM = w; memReadM = r; waddr = a; wdata = d;
    #1;
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  // Load with expected data; in the stalling build first checks the hazard stall
  // and waits (bounded) for the drain to clear it.
  task automatic load_expect(input string tag, input logic [31:0] a,
                             input logic [31:0] exp, input logic exp_stall);
    drive(1'b0, 1'b1, a, 32'h0);
`ifndef DRAM_WB_FWD_EN
    chk({tag, "_hazard"}, 32'(mem_stall), 32'(exp_stall));
    for (int n = 0; n < 2*WB && mem_stall; n++) tick;
`else
    if (exp_stall === 1'bx) tick;
`endif
    chk({tag, "_nostall"}, 32'(mem_stall), 32'h0);
    chk({tag, "_rdata"}, rdata, exp);
  endtask

  task automatic idle_drain(input string tag);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    repeat (WB + 1) tick;
    chk({tag, "_empty"}, 32'(wb_empty), 32'h1);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    chk("rst_empty", 32'(wb_empty), 32'h1);
    chk("rst_stall", 32'(mem_stall), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    tick; tick;
    rst = 1'b0;
    tick;

    // Store then immediate load of the same word
    drive(1'b1, 1'b0, 32'h10, 32'hDEADBEEF);
    chk("s10_stall", 32'(mem_stall), 32'h0);
    tick;
    chk("s10_notempty", 32'(wb_empty), 32'h0);
    load_expect("l10", 32'h10, 32'hDEADBEEF, 1'b1);
    idle_drain("d10");

    // Fill the buffer while loads block draining
    for (int i = 0; i < WB; i++) begin
      drive(1'b1, 1'b1, 32'h100 + 32'(4*i), 32'hA0 + 32'(i));
      chk("fill_stall", 32'(mem_stall), 32'h0);
      tick;
    end
    drive(1'b1, 1'b1, 32'h110, 32'hA4);
    chk("full_stall", 32'(mem_stall), 32'h1);
    chk("full_notempty", 32'(wb_empty), 32'h0);
    tick;
    chk("full_hold", 32'(mem_stall), 32'h1);
    drive(1'b1, 1'b0, 32'h110, 32'hA4);
    chk("full_drain_stall", 32'(mem_stall), 32'h1);
    tick;
    chk("after_drain_stall", 32'(mem_stall), 32'h0);
    tick;
    idle_drain("dfill");
    load_expect("l100", 32'h100, 32'hA0, 1'b0);
    load_expect("l10c", 32'h10C, 32'hA3, 1'b0);
    load_expect("l110", 32'h110, 32'hA4, 1'b0);

    // Two stores to one word: younger value wins
    drive(1'b1, 1'b0, 32'h20, 32'h1);
    tick;
    drive(1'b1, 1'b0, 32'h20, 32'h2);
    chk("s20b_stall", 32'(mem_stall), 32'h0);
    tick;
    load_expect("l20", 32'h20, 32'h2, 1'b1);
    idle_drain("d20");
    load_expect("l20ram", 32'h20, 32'h2, 1'b0);

    // Address aliasing modulo DEPTH_WORDS and ignored byte offset
    drive(1'b1, 1'b0, 32'h1000, 32'h7);
    tick;
    load_expect("l0alias", 32'h0, 32'h7, 1'b1);
    idle_drain("dalias");
    load_expect("l2alias", 32'h2, 32'h7, 1'b0);

    // Reset discards pending stores; RAM keeps prior contents
    drive(1'b1, 1'b0, 32'h40, 32'd11); tick;
    drive(1'b1, 1'b0, 32'h44, 32'd22); tick;
    drive(1'b1, 1'b0, 32'h48, 32'd33); tick;
    idle_drain("dpre");
    drive(1'b1, 1'b1, 32'h40, 32'd99); tick;
    drive(1'b1, 1'b1, 32'h44, 32'd98); tick;
    drive(1'b1, 1'b1, 32'h48, 32'd97); tick;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    chk("pend_notempty", 32'(wb_empty), 32'h0);
    rst = 1'b1;
    #1;
    chk("midrst_empty", 32'(wb_empty), 32'h1);
    chk("midrst_stall", 32'(mem_stall), 32'h0);
    tick;
    rst = 1'b0;
    tick;
    load_expect("l40", 32'h40, 32'd11, 1'b0);
    load_expect("l44", 32'h44, 32'd22, 1'b0);
    load_expect("l48", 32'h48, 32'd33, 1'b0);

    // Same-cycle load and store: load sees the old value
    drive(1'b1, 1'b0, 32'h30, 32'd5);
    tick;
    idle_drain("d30");
    drive(1'b1, 1'b1, 32'h30, 32'd9);
    chk("ls30_stall", 32'(mem_stall), 32'h0);
    chk("ls30_rdata", rdata, 32'd5);
    tick;
    load_expect("l30", 32'h30, 32'd9, 1'b1);
    drive(1'b0, 1'b0, 32'h30, 32'h0);
    chk("idle_rdata", rdata, 32'h0);
    idle_drain("dend");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
